// File: rtl/resp_chk_pkg.sv
// Shared types, defaults and helpers for the med1 response checker.
package resp_chk_pkg;

    localparam int WIDTH_DEF    = 10;
    localparam int PATTERNS_DEF = 8;
    localparam int SETTLE_DEF   = 4;
    localparam int CNT_W_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        if (val >= max_val) begin
            return val;
        end
        return val + 32'd1;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; expire is high on the last counting cycle of the settle window.
module settle_timer #(
    parameter int SETTLE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [TW-1:0] cnt_q;

    // Loaded with SETTLE-1 so that expire fires on the SETTLE-th enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= TW'(SETTLE - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/resp_checker.sv
// Applies patterns to the med1 identity/inverter network via valid/ready, waits a
// settle interval, then checks same==pat and inv==~pat and accumulates run results.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | after reset, waiting for start
// ST_WAIT   | pat_ready high, waiting for a pattern
// ST_SETTLE | pattern applied, settle timer counting down
// ST_CHECK  | sample and compare the network outputs
// ST_DONE   | run finished, results held until start or reset
module resp_checker
    import resp_chk_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int PATTERNS = PATTERNS_DEF,
    parameter int SETTLE   = SETTLE_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [WIDTH-1:0]     pat_data,
    input  logic [WIDTH-1:0]     same_in,
    input  logic [WIDTH-1:0]     inv_in,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     pat_idx,
    output logic                 first_fail_vld,
    output logic [CNT_W-1:0]     fail_idx,
    output logic [2*WIDTH-1:0]   fail_mask
);

    // Run sequencing uses an index wide enough for PATTERNS even when CNT_W is
    // narrower; the reported indices are its low CNT_W bits.
    localparam int IDX_MIN = ($clog2(PATTERNS) < 1) ? 1 : $clog2(PATTERNS);
    localparam int IDX_W   = (CNT_W > IDX_MIN) ? CNT_W : IDX_MIN;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t               state_q;
    state_t               state_nxt;
    logic                 pat_ready_q;
    logic                 pat_ready_nxt;
    logic                 done_q;
    logic                 done_nxt;
    logic                 pass_q;
    logic [WIDTH-1:0]     pat_q;
    logic [IDX_W-1:0]     idx_q;
    logic [CNT_W-1:0]     err_cnt_q;
    logic [CNT_W-1:0]     err_cnt_nxt;
    logic                 ffv_q;
    logic [CNT_W-1:0]     fail_idx_q;
    logic [2*WIDTH-1:0]   fail_mask_q;

    logic                 accept;
    logic                 start_ok;
    logic                 last_pat;
    logic                 mismatch;
    logic                 expire;

    assign accept   = (state_q == ST_WAIT) && pat_valid && pat_ready_q;
    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_pat = (idx_q == IDX_W'(PATTERNS - 1));
    assign mismatch = (same_in != pat_q) || (inv_in != ~pat_q);
    assign err_cnt_nxt = mismatch ? CNT_W'(sat_inc(32'(err_cnt_q), 32'(CNT_MAX))) : err_cnt_q;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .en     (state_q == ST_SETTLE),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:   if (start)  state_nxt = ST_WAIT;
            ST_WAIT:   if (accept) state_nxt = ST_SETTLE;
            ST_SETTLE: if (expire) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = last_pat ? ST_DONE : ST_WAIT;
            ST_DONE:   if (start)  state_nxt = ST_WAIT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so none is
    // combinational from an input.
    always_comb begin
        pat_ready_nxt = (state_nxt == ST_WAIT);
        done_nxt      = (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_ready_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pat_ready_q <= pat_ready_nxt;
            done_q      <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= '0;
        end else if (accept) begin
            pat_q <= pat_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            err_cnt_q   <= '0;
            ffv_q       <= 1'b0;
            fail_idx_q  <= '0;
            fail_mask_q <= '0;
            pass_q      <= 1'b0;
        end else if (start_ok) begin
            idx_q       <= '0;
            err_cnt_q   <= '0;
            ffv_q       <= 1'b0;
            fail_idx_q  <= '0;
            fail_mask_q <= '0;
            pass_q      <= 1'b0;
        end else if (state_q == ST_CHECK) begin
            err_cnt_q <= err_cnt_nxt;
            if (mismatch && !ffv_q) begin
                ffv_q       <= 1'b1;
                fail_idx_q  <= idx_q[CNT_W-1:0];
                fail_mask_q <= {same_in ^ pat_q, inv_in ^ ~pat_q};
            end
            if (last_pat) begin
                pass_q <= (err_cnt_nxt == '0);
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign pat_ready      = pat_ready_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign pat_idx        = idx_q[CNT_W-1:0];
    assign first_fail_vld = ffv_q;
    assign fail_idx       = fail_idx_q;
    assign fail_mask      = fail_mask_q;

endmodule

// File: tb/tb_resp_checker.sv
// Randomized directed bench for resp_checker: a default instance and a CNT_W=2
// instance share stimulus and are both checked against a per-run reference model.
module tb_resp_checker;

    localparam int WIDTH    = 10;
    localparam int PATTERNS = 8;
    localparam int SETTLE   = 4;
    localparam int CNT_W    = 8;
    localparam int SAT_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 pat_valid = 1'b0;
    logic [WIDTH-1:0]     pat_data = '0;
    logic [WIDTH-1:0]     same_in = '0;
    logic [WIDTH-1:0]     inv_in = '0;

    logic                 a_pat_ready, a_done, a_pass, a_ffv;
    logic [CNT_W-1:0]     a_err_cnt, a_pat_idx, a_fail_idx;
    logic [2*WIDTH-1:0]   a_fail_mask;
    logic                 b_pat_ready, b_done, b_pass, b_ffv;
    logic [SAT_W-1:0]     b_err_cnt, b_pat_idx, b_fail_idx;
    logic [2*WIDTH-1:0]   b_fail_mask;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] m_pat[$];
    logic [WIDTH-1:0] m_same[$];
    logic [WIDTH-1:0] m_inv[$];
    time              acc_t[$];

    resp_checker #(.WIDTH(WIDTH), .PATTERNS(PATTERNS), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid), .pat_ready(a_pat_ready),
        .pat_data(pat_data), .same_in(same_in), .inv_in(inv_in), .done(a_done), .pass(a_pass),
        .err_cnt(a_err_cnt), .pat_idx(a_pat_idx), .first_fail_vld(a_ffv), .fail_idx(a_fail_idx),
        .fail_mask(a_fail_mask)
    );

    resp_checker #(.WIDTH(WIDTH), .PATTERNS(PATTERNS), .SETTLE(SETTLE), .CNT_W(SAT_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid), .pat_ready(b_pat_ready),
        .pat_data(pat_data), .same_in(same_in), .inv_in(inv_in), .done(b_done), .pass(b_pass),
        .err_cnt(b_err_cnt), .pat_idx(b_pat_idx), .first_fail_vld(b_ffv), .fail_idx(b_fail_idx),
        .fail_mask(b_fail_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, a_pat_ready, 0);
        chk({tag, "_done"}, a_done, 0);
        chk({tag, "_pass"}, a_pass, 0);
        chk({tag, "_err"}, a_err_cnt, 0);
        chk({tag, "_idx"}, a_pat_idx, 0);
        chk({tag, "_ffv"}, a_ffv, 0);
        chk({tag, "_fidx"}, a_fail_idx, 0);
        chk({tag, "_mask"}, a_fail_mask, 0);
        chk({tag, "_b_err"}, b_err_cnt, 0);
        chk({tag, "_b_ready"}, b_pat_ready, 0);
    endtask

    // Present one pattern; network outputs glitch (always wrong) until 'd' cycles
    // after the accept edge, then settle to sf/iv. The checker sees whatever is
    // present after the accept edge plus SETTLE cycles.
    task automatic do_pattern(input logic [WIDTH-1:0] pat, input logic [WIDTH-1:0] sf,
                              input logic [WIDTH-1:0] iv, input int d, input bit pulse_start);
        int guard;
        logic [WIDTH-1:0] seen_s, seen_i;
        pat_valid = 1'b1;
        pat_data  = pat;
        guard = 0;
        while (a_pat_ready !== 1'b1 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("hs_timeout", 32'(guard < 40), 1);
        chk("pat_idx", a_pat_idx, 32'(m_pat.size()));
        chk("pat_idx_sat", b_pat_idx, 32'(m_pat.size() % 4));
        @(posedge clk);
        acc_t.push_back($time);
        #1;
        chk("ready_fall", a_pat_ready, 0);
        pat_valid = 1'b0;
        pat_data  = WIDTH'($urandom);
        same_in   = sf ^ WIDTH'($urandom_range(1, 1023));
        inv_in    = iv ^ WIDTH'($urandom_range(1, 1023));
        seen_s    = same_in;
        seen_i    = inv_in;
        if (pulse_start) start = 1'b1;
        for (int j = 1; j <= d; j++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (j == d) begin
                same_in = sf;
                inv_in  = iv;
            end else begin
                same_in = sf ^ WIDTH'($urandom_range(1, 1023));
                inv_in  = iv ^ WIDTH'($urandom_range(1, 1023));
            end
            if (j <= SETTLE) begin
                seen_s = same_in;
                seen_i = inv_in;
            end
        end
        m_pat.push_back(pat);
        m_same.push_back(seen_s);
        m_inv.push_back(seen_i);
    endtask

    task automatic start_run(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_pat.delete(); m_same.delete(); m_inv.delete(); acc_t.delete();
        chk({tag, "_start_ready"}, a_pat_ready, 1);
        chk({tag, "_start_done"}, a_done, 0);
        chk({tag, "_start_err"}, a_err_cnt, 0);
        chk({tag, "_start_idx"}, a_pat_idx, 0);
        chk({tag, "_start_ffv"}, a_ffv, 0);
        chk({tag, "_start_mask"}, a_fail_mask, 0);
    endtask

    task automatic finish_run(input string tag);
        int g, n, first;
        logic [2*WIDTH-1:0] mask;
        logic [WIDTH-1:0] p;
        bit mis;
        g = 0;
        while (a_done !== 1'b1 && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        chk({tag, "_done_timeout"}, 32'(g < 40), 1);
        n = 0; first = -1; mask = '0;
        foreach (m_pat[i]) begin
            p = m_pat[i];
            mis = (m_same[i] != p) || (m_inv[i] != ~p);
            if (mis) begin
                n++;
                if (first < 0) begin
                    first = i;
                    mask  = {m_same[i] ^ p, m_inv[i] ^ ~p};
                end
            end
        end
        chk({tag, "_done"}, a_done, 1);
        chk({tag, "_pass"}, a_pass, 32'(n == 0));
        chk({tag, "_err"}, a_err_cnt, 32'((n > 255) ? 255 : n));
        chk({tag, "_ffv"}, a_ffv, 32'(first >= 0));
        chk({tag, "_fidx"}, a_fail_idx, 32'((first >= 0) ? first : 0));
        chk({tag, "_mask"}, a_fail_mask, 32'(mask));
        chk({tag, "_idx_end"}, a_pat_idx, PATTERNS - 1);
        chk({tag, "_b_done"}, b_done, 1);
        chk({tag, "_b_pass"}, b_pass, 32'(n == 0));
        chk({tag, "_b_err"}, b_err_cnt, 32'((n > 3) ? 3 : n));
        chk({tag, "_b_fidx"}, b_fail_idx, 32'((first >= 0) ? (first % 4) : 0));
        chk({tag, "_b_mask"}, b_fail_mask, 32'(mask));
        chk({tag, "_b_idx_end"}, b_pat_idx, (PATTERNS - 1) % 4);
    endtask

    initial begin
        logic [WIDTH-1:0] p;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_ready", a_pat_ready, 0);

        // Clean run with outputs settling 3 cycles after accept.
        start_run("clean");
        for (int i = 0; i < PATTERNS; i++) begin
            p = (i == 0) ? 10'h2A5 : WIDTH'($urandom);
            do_pattern(p, p, ~p, 3, 1'b0);
        end
        finish_run("clean");
        chk("clean_pass_const", a_pass, 1);
        for (int i = 1; i < PATTERNS; i++) begin
            chk("clean_spacing", 32'(acc_t[i] - acc_t[i-1]), 60);
        end

        // Single stuck-at on same bit 0 at index 3; start pulsed in SETTLE at index 5.
        start_run("fault");
        for (int i = 0; i < PATTERNS; i++) begin
            if (i == 3) begin
                do_pattern(10'h3FF, 10'h3FE, 10'h000, 3, 1'b0);
            end else begin
                p = WIDTH'($urandom);
                do_pattern(p, p, ~p, 3, i == 5);
            end
        end
        finish_run("fault");
        chk("fault_err_const", a_err_cnt, 1);
        chk("fault_fidx_const", a_fail_idx, 3);
        chk("fault_mask_const", a_fail_mask, 20'h00400);

        // Outputs settle only 5 cycles after accept: everything is flagged.
        start_run("late");
        for (int i = 0; i < PATTERNS; i++) begin
            p = WIDTH'($urandom);
            do_pattern(p, p, ~p, 5, 1'b0);
        end
        finish_run("late");
        chk("late_err_const", a_err_cnt, 8);
        chk("late_fidx_const", a_fail_idx, 0);
        chk("sat_err_const", b_err_cnt, 3);

        // pat_valid held through DONE is ignored; start in DONE restarts at index 0.
        pat_valid = 1'b1;
        pat_data  = 10'h155;
        repeat (4) begin
            @(posedge clk); #1;
            chk("hold_done", a_done, 1);
            chk("hold_ready", a_pat_ready, 0);
            chk("hold_idx", a_pat_idx, PATTERNS - 1);
            chk("hold_sat_err", b_err_cnt, 3);
        end
        start_run("restart");
        for (int i = 0; i < PATTERNS; i++) begin
            p = WIDTH'($urandom);
            do_pattern(p, (i == 6) ? ~p : p, ~p, 2, 1'b0);
        end
        finish_run("restart");

        // Reset asserted mid-SETTLE discards partial results.
        start_run("rst");
        p = WIDTH'($urandom);
        do_pattern(p, p ^ 10'h080, ~p, 2, 1'b0);
        p = WIDTH'($urandom);
        do_pattern(p, p, ~p, 1, 1'b0);
        chk("rst_pre_err", a_err_cnt, 1);
        chk("rst_pre_ffv", a_ffv, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        pat_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_ready", a_pat_ready, 0);
        end
        pat_valid = 1'b0;
        start_run("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
